// File: rtl/msg_1030_pkg.sv
// Shared field widths, FSM encoding and a saturating-increment helper for the
// 1030 message scheduler.
package msg_1030_pkg;

  localparam int AC_MSG_W   = 24;
  localparam int AC_CLK_W   = 26;
  localparam int AC_UTC_W   = 6;
  localparam int AC_DRIFT_W = 13;
  localparam int AC_W       = AC_MSG_W + AC_CLK_W + AC_UTC_W + AC_DRIFT_W;

  localparam int PPS_W      = 32;
  localparam int DVAL_W     = 16;
  localparam int DRIFT_W    = PPS_W + DVAL_W;

  localparam int DROP_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sched_fifo.sv
// Circular FIFO with count-based full/empty; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sched_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [PW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, so the array can map onto plain RAM/flops without reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/msg_sched_1030.sv
// Serialises 1030 Mode A/C events and PPS drift reports onto one packager port.
// Optional issue statistics and counter clear: define MSG_SCHED_1030_STATS_EN.
module msg_sched_1030
  import msg_1030_pkg::*;
#(
  parameter int AC_DEPTH     = 4,
  parameter int DRIFT_DEPTH  = 2,
  parameter int GAP_CYCLES   = 2,
  parameter int AC_BURST_MAX = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ac_valid,
  input  logic [AC_MSG_W-1:0]          ac_message,
  input  logic [AC_CLK_W-1:0]          ac_clk_ts,
  input  logic [AC_UTC_W-1:0]          ac_utc_ts,
  input  logic signed [AC_DRIFT_W-1:0] ac_drift,
  input  logic                         drift_valid,
  input  logic [PPS_W-1:0]             drift_pps_count,
  input  logic signed [DVAL_W-1:0]     drift_value,
  input  logic                         out_ready,
  output logic                         out_valid_ac,
  output logic [AC_MSG_W-1:0]          out_ac_message,
  output logic [AC_CLK_W-1:0]          out_ac_clk_ts,
  output logic [AC_UTC_W-1:0]          out_ac_utc_ts,
  output logic signed [AC_DRIFT_W-1:0] out_ac_drift,
  output logic                         out_valid_drift,
  output logic [PPS_W-1:0]             out_pps_count,
  output logic signed [DVAL_W-1:0]     out_drift_value,
  output logic [DROP_W-1:0]            ac_drop_cnt,
  output logic [DROP_W-1:0]            drift_drop_cnt
`ifdef MSG_SCHED_1030_STATS_EN
  ,
  input  logic                         clr_stats,
  output logic [31:0]                  ac_issue_cnt,
  output logic [31:0]                  drift_issue_cnt
`endif
);

  localparam int BW = $clog2(AC_BURST_MAX + 1);
  localparam logic [BW-1:0] BURST_LIM = BW'(AC_BURST_MAX);
  localparam logic [3:0]    GAP_LAST  = 4'(GAP_CYCLES - 1);

  state_e            state_q, state_d;
  logic [AC_W-1:0]   ac_head, stage_q;
  logic [DRIFT_W-1:0] dr_head;
  logic              ac_full, ac_empty, dr_full, dr_empty;
  logic              ac_pop, dr_pop, pick_drift, sel_drift_q, clr;
  logic [BW-1:0]     burst_q;
  logic [3:0]        gap_q;

  sched_fifo #(.WIDTH(AC_W), .DEPTH(AC_DEPTH)) u_ac_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (ac_valid),
    .data_i ({ac_message, ac_clk_ts, ac_utc_ts, ac_drift}),
    .pop_i  (ac_pop),
    .data_o (ac_head),
    .full_o (ac_full),
    .empty_o(ac_empty)
  );

  sched_fifo #(.WIDTH(DRIFT_W), .DEPTH(DRIFT_DEPTH)) u_drift_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (drift_valid),
    .data_i ({drift_pps_count, drift_value}),
    .pop_i  (dr_pop),
    .data_o (dr_head),
    .full_o (dr_full),
    .empty_o(dr_empty)
  );

  assign pick_drift = !dr_empty && (ac_empty || burst_q >= BURST_LIM);

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    ac_pop  = 1'b0;
    dr_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (out_ready && !(ac_empty && dr_empty)) begin
          state_d = ST_ISSUE;
          if (pick_drift) dr_pop = 1'b1;
          else            ac_pop = 1'b1;
        end
      end
      ST_ISSUE: state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
      ST_GAP:   if (gap_q == GAP_LAST) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // The popped head is staged for one cycle so the strobe and its fields
  // appear together two edges after the event was sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      stage_q         <= '0;
      sel_drift_q     <= 1'b0;
      burst_q         <= '0;
      gap_q           <= '0;
      out_valid_ac    <= 1'b0;
      out_valid_drift <= 1'b0;
      out_ac_message  <= '0;
      out_ac_clk_ts   <= '0;
      out_ac_utc_ts   <= '0;
      out_ac_drift    <= '0;
      out_pps_count   <= '0;
      out_drift_value <= '0;
    end else begin
      state_q         <= state_d;
      out_valid_ac    <= 1'b0;
      out_valid_drift <= 1'b0;
      if (ac_pop) begin
        stage_q     <= ac_head;
        sel_drift_q <= 1'b0;
        if (!dr_empty && burst_q != BURST_LIM) burst_q <= burst_q + 1'b1;
      end
      if (dr_pop) begin
        stage_q     <= AC_W'(dr_head);
        sel_drift_q <= 1'b1;
        burst_q     <= '0;
      end
      if (state_q == ST_ISSUE) begin
        if (sel_drift_q) begin
          out_valid_drift                  <= 1'b1;
          {out_pps_count, out_drift_value} <= stage_q[DRIFT_W-1:0];
        end else begin
          out_valid_ac <= 1'b1;
          {out_ac_message, out_ac_clk_ts, out_ac_utc_ts, out_ac_drift} <= stage_q;
        end
      end
      if (state_q == ST_GAP) gap_q <= (gap_q == GAP_LAST) ? 4'd0 : gap_q + 1'b1;
    end
  end

`ifdef MSG_SCHED_1030_STATS_EN
  assign clr = clr_stats;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ac_issue_cnt    <= '0;
      drift_issue_cnt <= '0;
    end else if (clr) begin
      ac_issue_cnt    <= '0;
      drift_issue_cnt <= '0;
    end else begin
      if (out_valid_ac)    ac_issue_cnt    <= ac_issue_cnt + 1'b1;
      if (out_valid_drift) drift_issue_cnt <= drift_issue_cnt + 1'b1;
    end
  end
`else
  assign clr = 1'b0;
`endif

  // A strobe into a full queue is lost unless that queue pops this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ac_drop_cnt    <= '0;
      drift_drop_cnt <= '0;
    end else if (clr) begin
      ac_drop_cnt    <= '0;
      drift_drop_cnt <= '0;
    end else begin
      if (ac_valid && ac_full && !ac_pop)    ac_drop_cnt    <= sat_inc(ac_drop_cnt);
      if (drift_valid && dr_full && !dr_pop) drift_drop_cnt <= sat_inc(drift_drop_cnt);
    end
  end

endmodule

// File: doc/msg_sched_1030.md
Name: msg_sched_1030

Overview:
- Queues 1030 Mode A/C reply events and PPS drift reports, then issues them one at a time to the 1030 message packager.
- Guarantees the packager never sees simultaneous valids, so no drift report is silently lost behind a Mode A/C event.
- Applies downstream back-pressure, a minimum inter-message gap, and an anti-starvation limit for drift reports.
- Sits between the 1030 detectors/PPS drift logic and the packager.

Parameters:
- AC_DEPTH, 4: Mode A/C queue depth in entries; power of 2, ≥2.
- DRIFT_DEPTH, 2: drift queue depth in entries; power of 2, ≥2.
- GAP_CYCLES, 2: idle cycles forced after each issue; 0..15.
- AC_BURST_MAX, 4: maximum consecutive A/C grants while a drift entry waits; ≥1.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- ac_valid, in, 1: one-cycle A/C event strobe.
- ac_message, in, 24: A/C reply code.
- ac_clk_ts, in, 26: clock-count timestamp.
- ac_utc_ts, in, 6: UTC seconds timestamp.
- ac_drift, in, 13 (signed): drift at the time of the event.
- drift_valid, in, 1: one-cycle drift report strobe.
- drift_pps_count, in, 32: PPS count.
- drift_value, in, 16 (signed): drift value.
- out_ready, in, 1: downstream can accept a message (FIFO not almost-full).
- out_valid_ac, out, 1: one-cycle issue strobe for an A/C message.
- out_ac_message / out_ac_clk_ts / out_ac_utc_ts / out_ac_drift, out, 24/26/6/13: A/C fields.
- out_valid_drift, out, 1: one-cycle issue strobe for a drift report.
- out_pps_count / out_drift_value, out, 32/16: drift fields.
- ac_drop_cnt, out, 16: saturating count of A/C events dropped on a full queue.
- drift_drop_cnt, out, 16: saturating count of drift reports dropped on a full queue.

Behaviour:
- Reset (async, rst_n=0): all outputs 0; queues empty; FSM in IDLE; burst and gap counters 0.
- Queues:
  - Push when the strobe is high and the queue is not full, or is full but popped in the same cycle.
  - Otherwise drop the event and increment its drop counter; counters saturate at 16'hFFFF.
  - A/C and drift pushes in the same cycle are independent; both are accepted.
- FSM IDLE:
  - Leaves IDLE when out_ready=1 and at least one queue is non-empty.
  - Selects drift if the drift queue is non-empty and (the A/C queue is empty or burst_cnt ≥ AC_BURST_MAX); otherwise selects A/C.
  - Pops the selected queue and goes to ISSUE.
- ISSUE (1 cycle):
  - Asserts exactly one of out_valid_ac / out_valid_drift.
  - Drives that class's data registers; the other class's registers hold their value.
  - Data registers stay stable until that class's next issue.
  - burst_cnt increments on an A/C grant when the drift queue is non-empty, and clears on any drift grant.
  - Next state: GAP if GAP_CYCLES>0, else IDLE.
- GAP: counts GAP_CYCLES cycles, then returns to IDLE. out_ready is ignored during GAP.
- Latency: strobe sampled at edge k into an empty queue, FSM idle, out_ready=1 → out_valid_* high after edge k+2.
- Throughput: one message per GAP_CYCLES+2 cycles.
- out_ready is sampled only in IDLE. Deassertion after selection does not cancel the issue.
- out_valid_ac and out_valid_drift are never high together.
- Queue order within a class is FIFO.

Optional Feature:
- Macro MSG_SCHED_1030_STATS_EN.
- When defined, adds outputs ac_issue_cnt[31:0] and drift_issue_cnt[31:0].
  - Wrapping counts of issue strobes, reset to 0.
  - Adds a clr_stats input (1 bit, synchronous): zeroes the issue counters and both drop counters. A clear has priority over a same-cycle increment.
- When undefined, these ports do not exist and the drop counters clear only on reset.

Decomposition:
- Shared package msg_1030_pkg:
  - A/C field widths (24/26/6/13) and drift widths (32/16).
  - FSM state encodings IDLE/ISSUE/GAP.
  - Drop-counter width 16.
- Sub-module sched_fifo:
  - Parameterised WIDTH and DEPTH, synchronous push/pop, full/empty flags, push-when-full-with-pop allowed.
  - Instantiated twice: WIDTH=69 for A/C, WIDTH=48 for drift.

Test Plan:
1. Single A/C event ac_message=24'h0A5C21, ac_clk_ts=26'h123456 at edge 10, out_ready=1 → out_valid_ac high after edge 12 with matching fields; no drift strobe.
2. ac_valid and drift_valid in the same cycle, empty queues → A/C issued first, drift issued exactly GAP_CYCLES+2=4 cycles later; drop counters stay 0.
3. 6 back-to-back A/C strobes with out_ready=0, AC_DEPTH=4 → ac_drop_cnt=2; after out_ready=1, first 4 messages issue in order.
4. A/C queue held full, one drift entry pending, AC_BURST_MAX=4 → drift issued after exactly 4 A/C grants.
5. Assert rst_n=0 during GAP with 3 entries queued → outputs 0 immediately; after release, nothing issues until a new strobe arrives.
6. drift_valid 3× while idle with out_ready=0, DRIFT_DEPTH=2 → drift_drop_cnt=1. Under STATS_EN, pulse clr_stats → drift_drop_cnt=0.
